img2col_window_pu: RTL
======================

Name: img2col_window_pu

Overview:
- Parametrised img2col processing unit; next generation of the fixed 5x5 PU.
- Assembles a KxK input window from pixels written over two AXI-fed write ports.
- Supports full loads and stride-S horizontal slides that reuse the K-S overlap columns internally.
- Presents the window to the MAC array via a valid/ready handshake and forwards the overlap columns to the neighbouring PU.

Parameters:
DATA_W, 16, pixel width in bits
K, 5, kernel dimension (window is KxK); K>=2
S, 1, horizontal stride in columns; 1<=S<K
ADDR_W, $clog2(K*K), write-address width

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
start  in  1  begin a window; sampled only in IDLE
full_load  in  1  with start: 1 = load all K*K pixels, 0 = slide (load K*S new pixels)
wr_en1  in  1  port-1 write strobe
wr_en2  in  1  port-2 write strobe
adrs_in1  in  ADDR_W  port-1 pixel index
adrs_in2  in  ADDR_W  port-2 pixel index
new1  in  DATA_W  port-1 pixel
new2  in  DATA_W  port-2 pixel
out_ready  in  1  consumer accepts window
out_valid  out  1  window complete and stable
out  out  DATA_W x K*K  window, out[r*K+c] = row r, col c
neighbour_out  out  DATA_W x K*(K-S)  overlap columns, [r*(K-S)+c] = win[r][c+S]
neighbour_out_flag  out  1  one-cycle pulse; neighbour_out valid
busy  out  1  state != IDLE
addr_err  out  1  one-cycle pulse on a dropped or illegal request

Behaviour:
- Reset (async, nrst=0): all window registers = 0; state = IDLE; count = 0; reserved_valid = 0; out_valid, neighbour_out_flag, busy and addr_err = 0. Reset mid-LOAD/EMIT aborts without emitting.
- IDLE, start=1:
  - expected = full_load ? K*K : K*S.
  - If full_load=0 and reserved_valid=0: addr_err pulses and expected is forced to K*K.
  - count = 0; next state LOAD. Writes in IDLE are ignored.
- LOAD:
  - Full load: index a maps to row a/K, col a%K; legal range 0..K*K-1.
  - Slide: index a maps to row a/S, col K-S+a%S; legal range 0..K*S-1.
  - Out-of-range index: write dropped, not counted, addr_err pulses.
  - Both ports enabled with equal legal index: port 2 data wins and the pair counts as one write. Otherwise each legal write counts as one.
  - Count saturates at expected. When count reaches expected, the next state is EMIT. out_valid rises the cycle after the last write.
  - start is ignored while busy.
- EMIT:
  - out_valid=1; out and neighbour_out are held stable; writes are ignored.
  - On out_valid & out_ready:
    - win[r][c] <= win[r][c+S] for c<K-S; the new columns keep their old data until overwritten.
    - reserved_valid <= 1; neighbour_out_flag pulses in the same cycle, using pre-shift data.
    - Next state IDLE; out_valid falls the next cycle.
  - Back-to-back: start may be asserted in the cycle after the handshake.
- Latency: full load with 2 writes/cycle takes ceil(K*K/2) LOAD cycles plus 1; slide takes ceil(K*S/2) plus 1.
- Widths: index decode is by constant division/modulo on ADDR_W; no arithmetic is performed on data.

Decomposition:
- img2col_pkg:
  - state enum {IDLE, LOAD, EMIT};
  - function idx2rc(full_load, a) returning {row, col, legal};
  - localparams NEW_FULL=K*K, NEW_SLIDE=K*S.
- Sub-module window_regfile:
  - KxK DATA_W registers with two decoded write ports (port 2 priority);
  - a one-cycle shift-by-S enable;
  - flat out and neighbour_out views.
- Controller FSM and counter stay in the top.

Test Plan:
- Full load, K=5 S=1: start full_load=1; write index i data i+1, two per cycle for 13 cycles (last cycle port 1 only) -> out_valid in cycle 14; out[i]=i+1; busy=1 throughout.
- Slide after previous case: handshake; start full_load=0; write 101..105 at indices 0..4 -> out row r = {r*5+2..r*5+5, 101+r}; neighbour_out_flag pulsed at the prior handshake with neighbour_out[r*4+c]=r*5+c+2.
- Collision: both ports index 7 with data 0xAAAA / 0x5555 -> win[1][2]=0x5555; count+1; one extra write cycle needed.
- Illegal: full load index 25, or slide index 5 -> addr_err pulse, no count, no register change; start slide after reset -> addr_err and 25 writes required.
- Backpressure: out_ready=0 for 10 cycles in EMIT with writes toggling -> out unchanged, out_valid held, no flag; out_ready=1 -> flag pulse, IDLE next cycle.
- Reset: nrst=0 mid-LOAD -> all outputs 0 immediately; after release, a slide start triggers addr_err.

Source files
------------

// File: rtl/img2col_window_pu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : img2col_pkg
// Purpose  : Shared types and pixel-index decode for the img2col window PU.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package img2col_pkg;

  localparam int RC_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [RC_W-1:0] row;
    logic [RC_W-1:0] col;
    logic            legal;
  } rc_t;

  // Slides only refresh the rightmost S columns, so their index space is K*S.
  function automatic rc_t idx2rc(input logic        full_load,
                                 input int unsigned a,
                                 input int unsigned k,
                                 input int unsigned s);
    rc_t r;
    r = '0;
    if (full_load) begin
      r.legal = (a < k * k);
      r.row   = RC_W'(a / k);
      r.col   = RC_W'(a % k);
    end else begin
      r.legal = (a < k * s);
      r.row   = RC_W'(a / s);
      r.col   = RC_W'(k - s + (a % s));
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/img2col_window_pu_window_regfile.sv
`default_nettype none
// ============================================================================
// Module   : window_regfile
// Purpose  : KxK pixel window with two decoded write ports and a stride shift.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module window_regfile
  import img2col_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int K      = 5,
  parameter int S      = 1
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             we1_i,
  input  logic [RC_W-1:0]                  row1_i,
  input  logic [RC_W-1:0]                  col1_i,
  input  logic [DATA_W-1:0]                data1_i,
  input  logic                             we2_i,
  input  logic [RC_W-1:0]                  row2_i,
  input  logic [RC_W-1:0]                  col2_i,
  input  logic [DATA_W-1:0]                data2_i,
  input  logic                             shift_i,
  output logic [K*K-1:0][DATA_W-1:0]       win_o,
  output logic [K*(K-S)-1:0][DATA_W-1:0]   nb_o
);

  logic [K*K-1:0][DATA_W-1:0] win_w;

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      logic [DATA_W-1:0] cell_q;
      logic [DATA_W-1:0] src_w;
      logic              hit1_w;
      logic              hit2_w;

      assign hit1_w = we1_i && (row1_i == RC_W'(r)) && (col1_i == RC_W'(c));
      assign hit2_w = we2_i && (row2_i == RC_W'(r)) && (col2_i == RC_W'(c));

      // Incoming columns keep their contents on a shift until rewritten.
      if (c < K - S) begin : g_src_shift
        assign src_w = win_w[r*K+c+S];
      end else begin : g_src_keep
        assign src_w = cell_q;
      end

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          cell_q <= '0;
        end else if (shift_i) begin
          cell_q <= src_w;
        end else if (hit2_w) begin
          cell_q <= data2_i;
        end else if (hit1_w) begin
          cell_q <= data1_i;
        end
      end

      assign win_w[r*K+c] = cell_q;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_nb_row
    for (genvar c = 0; c < K - S; c++) begin : g_nb_col
      assign nb_o[r*(K-S)+c] = win_w[r*K+c+S];
    end
  end

  assign win_o = win_w;

endmodule
`default_nettype wire

// File: rtl/img2col_window_pu.sv
`default_nettype none
// ============================================================================
// Module   : img2col_window_pu
// Purpose  : img2col PU: assembles KxK windows (full or stride-S slide) for MACs.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module img2col_window_pu
  import img2col_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int K      = 5,
  parameter int S      = 1,
  parameter int ADDR_W = $clog2(K*K)
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             start,
  input  logic                             full_load,
  input  logic                             wr_en1,
  input  logic                             wr_en2,
  input  logic [ADDR_W-1:0]                adrs_in1,
  input  logic [ADDR_W-1:0]                adrs_in2,
  input  logic [DATA_W-1:0]                new1,
  input  logic [DATA_W-1:0]                new2,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [K*K-1:0][DATA_W-1:0]       out,
  output logic [K*(K-S)-1:0][DATA_W-1:0]   neighbour_out,
  output logic                             neighbour_out_flag,
  output logic                             busy,
  output logic                             addr_err
);

  localparam int NEW_FULL  = K * K;
  localparam int NEW_SLIDE = K * S;
  localparam int CNT_W     = $clog2(K*K + 1);

  state_e            state_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  expected_q;
  logic              mode_full_q;
  logic              reserved_q;
  logic              out_valid_q;
  logic              addr_err_q;

  rc_t               rc1_w;
  rc_t               rc2_w;
  logic              in_load_w;
  logic              v1_w;
  logic              v2_w;
  logic              bad_w;
  logic              start_err_w;
  logic              handshake_w;
  logic              start_full_w;
  logic [1:0]        n_wr_w;
  logic [CNT_W:0]    sum_w;
  logic [CNT_W-1:0]  count_d;

  assign rc1_w = idx2rc(mode_full_q, 32'(adrs_in1), K, S);
  assign rc2_w = idx2rc(mode_full_q, 32'(adrs_in2), K, S);

  assign in_load_w   = (state_q == LOAD);
  assign v1_w        = in_load_w && wr_en1 && rc1_w.legal;
  assign v2_w        = in_load_w && wr_en2 && rc2_w.legal;
  assign bad_w       = in_load_w && ((wr_en1 && !rc1_w.legal) || (wr_en2 && !rc2_w.legal));
  assign start_err_w = (state_q == IDLE) && start && !full_load && !reserved_q;
  assign handshake_w = out_valid_q && out_ready;
  // A slide with no prior window has no overlap to reuse, so it loads everything.
  assign start_full_w = full_load || !reserved_q;

  // Both ports hitting the same pixel is a single write.
  assign n_wr_w  = (v1_w && v2_w && (adrs_in1 == adrs_in2)) ? 2'd1
                 : ({1'b0, v1_w} + {1'b0, v2_w});
  assign sum_w   = {1'b0, count_q} + {{(CNT_W-1){1'b0}}, n_wr_w};
  assign count_d = (sum_w >= {1'b0, expected_q}) ? expected_q : sum_w[CNT_W-1:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      expected_q  <= '0;
      mode_full_q <= 1'b1;
      reserved_q  <= 1'b0;
      out_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      addr_err_q <= start_err_w || bad_w;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= LOAD;
            count_q     <= '0;
            mode_full_q <= start_full_w;
            expected_q  <= start_full_w ? CNT_W'(NEW_FULL) : CNT_W'(NEW_SLIDE);
          end
        end
        LOAD: begin
          count_q <= count_d;
          if (count_d == expected_q) begin
            state_q     <= EMIT;
            out_valid_q <= 1'b1;
          end
        end
        EMIT: begin
          if (handshake_w) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            reserved_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  window_regfile #(
    .DATA_W (DATA_W),
    .K      (K),
    .S      (S)
  ) u_regfile (
    .clk     (clk),
    .nrst    (nrst),
    .we1_i   (v1_w),
    .row1_i  (rc1_w.row),
    .col1_i  (rc1_w.col),
    .data1_i (new1),
    .we2_i   (v2_w),
    .row2_i  (rc2_w.row),
    .col2_i  (rc2_w.col),
    .data2_i (new2),
    .shift_i (handshake_w),
    .win_o   (out),
    .nb_o    (neighbour_out)
  );

  assign out_valid          = out_valid_q;
  assign busy               = (state_q != IDLE);
  assign addr_err           = addr_err_q;
  assign neighbour_out_flag = handshake_w;

endmodule
`default_nettype wire
